// File: rtl/up_down_scheduler.sv
// Shared up/down counter granted to one of two requesters for a burst of len steps.
// Ties are broken round-robin; each burst ends with a one-cycle done pulse for its owner.
module up_down_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req_up,
  input  logic             req_down,
  input  logic [WIDTH-1:0] len,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             gnt_up,
  output logic             gnt_down,
  output logic             busy,
  output logic             done_up,
  output logic             done_down
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic             last_up;
  logic             win_up;

  // Up wins alone or on a tie when down owned the previous burst.
  assign win_up = req_up && (!req_down || !last_up);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      count     <= '0;
      dir       <= 1'b1;
      gnt_up    <= 1'b0;
      gnt_down  <= 1'b0;
      busy      <= 1'b0;
      done_up   <= 1'b0;
      done_down <= 1'b0;
      remaining <= '0;
      last_up   <= 1'b0;
    end else begin
      done_up   <= 1'b0;
      done_down <= 1'b0;
      case (state)
        IDLE: begin
          if (req_up || req_down) begin
            state     <= RUN;
            remaining <= len;
            dir       <= win_up;
            gnt_up    <= win_up;
            gnt_down  <= !win_up;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          count     <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
          remaining <= remaining - WIDTH'(1);
          // len of 0 starts at zero and wraps, giving 2^WIDTH steps before reaching 1.
          if (remaining == WIDTH'(1)) begin
            state     <= DONE;
            gnt_up    <= 1'b0;
            gnt_down  <= 1'b0;
            busy      <= 1'b0;
            done_up   <= dir;
            done_down <= !dir;
          end
        end
        DONE: begin
          last_up <= dir;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (clr) count <= '0;
    end
  end

endmodule

// File: tb/tb_up_down_scheduler.sv
// Scoreboard bench for up_down_scheduler: stimulus pushes expected burst results,
// a monitor pops and compares them at each done pulse.
module tb_up_down_scheduler;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       req_up = 1'b0;
  logic       req_down = 1'b0;
  logic [3:0] len = '0;
  logic       clr = 1'b0;
  logic [3:0] count;
  logic       dir;
  logic       gnt_up;
  logic       gnt_down;
  logic       busy;
  logic       done_up;
  logic       done_down;

  typedef struct {
    bit         up;
    logic [3:0] cnt;
    int         steps;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         run_cnt = 0;
  logic [3:0] m_count = '0;
  bit         m_last_up = 1'b0;

  up_down_scheduler #(.WIDTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .req_up(req_up), .req_down(req_down), .len(len), .clr(clr),
    .count(count), .dir(dir), .gnt_up(gnt_up), .gnt_down(gnt_down), .busy(busy),
    .done_up(done_up), .done_down(done_down)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle_cycles(input int n, input bit c);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      req_up = 1'b0; req_down = 1'b0; len = 4'($urandom); clr = c;
      if (c) m_count = '0;
    end
  endtask

  // One complete burst: grant edge, len steps, DONE cycle; the following drive is the IDLE cycle.
  task automatic apply_stimulus(input bit ru, input bit rd, input logic [3:0] l, input int clr_step);
    bit win;
    int steps;
    exp_t e;
    @(negedge CLK);
    req_up = ru; req_down = rd; len = l; clr = 1'b0;
    win = ru && (!rd || !m_last_up);
    steps = (l == 4'd0) ? 16 : int'(l);
    for (int i = 1; i <= steps; i++) begin
      @(negedge CLK);
      req_up = 1'($urandom); req_down = 1'($urandom); len = 4'($urandom);
      clr = (i == clr_step);
      if (clr) m_count = '0;
      else if (win) m_count = (m_count + 4'd1) % 16;
      else m_count = (m_count + 4'd15) % 16;
    end
    e.up = win; e.cnt = m_count; e.steps = steps;
    sb.push_back(e);
    @(negedge CLK);
    req_up = 1'($urandom); req_down = 1'($urandom); len = 4'($urandom);
    clr = ($urandom_range(0, 5) == 0);
    if (clr) m_count = '0;
    m_last_up = win;
  endtask

  // Monitor: exclusivity every cycle, burst result at every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        run_cnt = 0;
      end else begin
        check_output("gnt_exclusive", 32'(gnt_up & gnt_down), 32'd0);
        check_output("busy_vs_gnt", 32'(busy), 32'(gnt_up | gnt_down));
        if (busy) run_cnt++;
        if (done_up || done_down) begin
          if (sb.size() == 0) begin
            check_output("unexpected_done", {done_up, done_down}, 32'd0);
          end else begin
            e = sb.pop_front();
            check_output("done_up", 32'(done_up), 32'(e.up));
            check_output("done_down", 32'(done_down), 32'(!e.up));
            check_output("dir", 32'(dir), 32'(e.up));
            check_output("count_at_done", 32'(count), 32'(e.cnt));
            check_output("run_cycles", 32'(run_cnt), 32'(e.steps));
          end
          run_cnt = 0;
        end
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_output("reset_state", {count, dir, gnt_up, gnt_down, busy, done_up, done_down}, 32'b0000_100000);
    end

    apply_stimulus(1'b1, 1'b0, 4'd3, 0);
    idle_cycles(1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'd2, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 4'd1, 0);
    idle_cycles(1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd5, 0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 0);
    idle_cycles(1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd4, 2);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      apply_stimulus(r[0], r[1], 4'($urandom), $urandom_range(0, 8));
    end

    // Abort a burst in its second RUN cycle.
    idle_cycles(1, 1'b1);
    @(negedge CLK);
    req_up = 1'b1; req_down = 1'b0; len = 4'd8; clr = 1'b0;
    @(negedge CLK);
    req_up = 1'b0;
    @(posedge CLK);
    #2;
    check_output("pre_abort_count", 32'(count), 32'd1);
    Reset = 1'b0;
    #1;
    check_output("abort_reset_state", {count, dir, gnt_up, gnt_down, busy, done_up, done_down}, 32'b0000_100000);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    m_count = '0;
    m_last_up = 1'b0;
    idle_cycles(3, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'd1, 0);
    apply_stimulus(1'b1, 1'b1, 4'd2, 0);

    idle_cycles(4, 1'b0);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_down_scheduler.md
UP_DOWN_SCHEDULER -- requirements
Module: up_down_scheduler

Interface
REQ-001 Parameter: WIDTH, 4, counter and burst-length width in bits.
REQ-002 Port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req_up  input  1  up-requester asks for a burst of up-counts; level-sensitive.
REQ-005 Port: req_down  input  1  down-requester asks for a burst of down-counts; level-sensitive.
REQ-006 Port: len  input  WIDTH  burst length in steps, sampled at grant; 0 means 2^WIDTH steps.
REQ-007 Port: clr  input  1  synchronous clear of count.
REQ-008 Port: count  output  WIDTH  shared counter value.
REQ-009 Port: dir  output  1  direction / mux select: 1 = up, 0 = down.
REQ-010 Port: gnt_up  output  1  up-requester owns the counter.
REQ-011 Port: gnt_down  output  1  down-requester owns the counter.
REQ-012 Port: busy  output  1  high while a burst is in progress.
REQ-013 Port: done_up  output  1  one-cycle pulse when an up burst completes.
REQ-014 Port: done_down  output  1  one-cycle pulse when a down burst completes.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE, no request: SHALL stay in IDLE; count holds.
REQ-017 IDLE, at least one request at a rising edge: SHALL select a winner, latch len into a remaining-step register, set dir (1 for up, 0 for down) and enter RUN at that edge.
REQ-018 Arbitration: a single requester wins outright; when both request, the requester that did not win last SHALL win (round-robin).
REQ-019 RUN, each edge: count SHALL step by +1 (dir=1) or -1 (dir=0) modulo 2^WIDTH, and remaining SHALL decrement by 1.
REQ-020 RUN: the edge that performs the last step SHALL move the FSM to DONE, so exactly len steps occur (2^WIDTH when len=0).
REQ-021 DONE: SHALL last exactly one cycle, pulse done_up or done_down for the winner, record the winner for round-robin, then return to IDLE.
REQ-022 A new grant SHALL NOT be issued in DONE, so back-to-back bursts are separated by one DONE cycle and one IDLE cycle.
REQ-023 Ownership outputs: gnt_up or gnt_down and busy SHALL be high exactly during RUN cycles; at most one gnt SHALL be high at any time.
REQ-024 Latency: a request sampled at edge k gives gnt high after edge k; the first count change occurs at edge k+1.
REQ-025 Request deassertion or a len change during RUN SHALL be ignored; the burst completes.
REQ-026 dir SHALL hold its last value outside RUN.
REQ-027 clr high at an edge SHALL set count to 0 in any state, overriding that cycle's step; FSM state and remaining SHALL still update normally.
REQ-028 Count wrap-around: up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1; no other flags.

Reset
REQ-029 Reset low SHALL immediately (asynchronously) force: state IDLE, count 0, dir 1, gnt_up 0, gnt_down 0, busy 0, done_up 0, done_down 0, remaining 0, last winner = down (so up wins the first tie).
REQ-030 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-031 After Reset releases, the first grant SHALL be possible at the first rising edge at which a request is sampled.

Verification
REQ-032 Reset low then released, no requests -> count=0, dir=1, all gnt/done/busy 0 for 10 cycles.
REQ-033 count=0, req_up with len=3 -> gnt_up high 3 cycles, count 1,2,3, done_up one cycle, then IDLE with count=3.
REQ-034 count=0, req_down with len=2 -> count 15 then 14, dir=0, a single done_down pulse.
REQ-035 req_up and req_down held together, len=1 -> grants alternate up, down, up; dir follows each grant; gnt never both high.
REQ-036 len=0, req_up from count=5 -> 16 up-steps, count returns to 5, done_up after the 16th step.
REQ-037 clr pulsed at the 2nd RUN edge of a len=4 up burst from 0 -> count 1,0,1,2 and done_up on schedule.
REQ-037a Reset low at the 2nd RUN cycle -> all outputs return to reset values immediately, with no done pulse.
